// File: rtl/exp_normalize_block.sv
// Softmax normalisation stage: gathers one frame of exponent samples,
// accumulates their sum, then emits each sample divided by that sum
// (unsigned fixed-point, same Q format in and out) in arrival order.
// One restoring-division quotient bit is produced per cycle.
module exp_normalize_block #(
    parameter int data_size      = 32,
    parameter int frac_size      = 16,
    parameter int number_of_data = 10
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [data_size-1:0] data_i,
    input  logic                 data_valid_i,
    output logic                 busy_o,
    output logic                 drop_o,
    output logic [data_size-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 done_o
);

    localparam int ptr_w = (number_of_data > 1) ? $clog2(number_of_data) : 1;
    // Sum of number_of_data samples can never overflow this width.
    localparam int sum_w = data_size + $clog2(number_of_data);
    // Numerator is the sample pre-scaled by 2^frac_size.
    localparam int num_w = data_size + frac_size;
    localparam int cnt_w = $clog2(num_w);

    localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(number_of_data - 1);
    localparam logic [cnt_w-1:0] last_iter = cnt_w'(num_w - 1);

    typedef enum logic [1:0] {COLLECT, LOAD, DIV, OUT} state_t;

    state_t               state;
    logic [ptr_w-1:0]     wr_ptr;
    logic [ptr_w-1:0]     rd_ptr;
    logic [sum_w-1:0]     sum;
    // Holds the numerator while dividing; quotient bits shift in from the
    // bottom, so after num_w steps it holds the quotient.
    logic [num_w-1:0]     num;
    logic [sum_w-1:0]     rem;
    logic [cnt_w-1:0]     iter;
    logic [data_size-1:0] buffer [number_of_data];

    // One restoring-division step: bring down the next numerator bit and
    // subtract the divisor when it fits. A zero sum never "fits", so an
    // all-zero frame yields a zero quotient instead of all ones.
    logic [sum_w:0] rem_shift;
    logic [sum_w:0] rem_sub;
    logic [sum_w:0] rem_sel;
    logic           q_bit;
    logic           rem_sel_unused;

    assign rem_shift      = {rem, num[num_w-1]};
    assign rem_sub        = rem_shift - {1'b0, sum};
    assign q_bit          = (sum != '0) && (rem_shift >= {1'b0, sum});
    // Remainder is always below the divisor, so the top bit is never needed.
    assign rem_sel        = q_bit ? rem_sub : rem_shift;
    assign rem_sel_unused = rem_sel[sum_w];

    // Sample storage; written only while collecting, no reset needed since
    // every slot is rewritten before it is read in a frame.
    always_ff @(posedge clock_i) begin
        if (state == COLLECT && data_valid_i) begin
            buffer[wr_ptr] <= data_i;
        end
    end

    // Control FSM with the datapath registers and registered outputs.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= COLLECT;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            sum          <= '0;
            num          <= '0;
            rem          <= '0;
            iter         <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            done_o       <= 1'b0;
            drop_o       <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            done_o       <= 1'b0;
            // Anything offered outside COLLECT is discarded and flagged.
            drop_o       <= data_valid_i && (state != COLLECT);

            case (state)
                COLLECT: begin
                    if (data_valid_i) begin
                        sum <= sum + sum_w'(data_i);
                        if (wr_ptr == last_ptr) begin
                            wr_ptr <= '0;
                            state  <= LOAD;
                            busy_o <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + ptr_w'(1);
                        end
                    end
                end

                LOAD: begin
                    num   <= {buffer[rd_ptr], {frac_size{1'b0}}};
                    rem   <= '0;
                    iter  <= '0;
                    state <= DIV;
                end

                DIV: begin
                    num  <= {num[num_w-2:0], q_bit};
                    rem  <= rem_sel[sum_w-1:0];
                    iter <= iter + cnt_w'(1);
                    if (iter == last_iter) begin
                        state <= OUT;
                    end
                end

                OUT: begin
                    // Quotient never exceeds 1.0, so truncation loses nothing.
                    data_o       <= num[data_size-1:0];
                    data_valid_o <= 1'b1;
                    if (rd_ptr == last_ptr) begin
                        done_o <= 1'b1;
                        rd_ptr <= '0;
                        sum    <= '0;
                        state  <= COLLECT;
                        busy_o <= 1'b0;
                    end else begin
                        rd_ptr <= rd_ptr + ptr_w'(1);
                        state  <= LOAD;
                    end
                end

                default: begin
                    state  <= COLLECT;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
